fp_muldiv_stim_gen: RTL and testbench
=====================================

FP_MULDIV_STIM_GEN -- requirements
Module: fp_muldiv_stim_gen

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8, meaning operand exponent width (legal 5..8).
REQ-002 The block SHALL have parameter MAN_W, default 23, meaning operand mantissa width (legal 10..23); W = 1+EXP_W+MAN_W.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning transaction counter width.
REQ-004 The block SHALL have parameters SEED_A, default 32'h1234_5678, and SEED_B, default 32'h7FFF_FFFF, meaning nonzero LFSR seeds.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-006 The block SHALL have port arst, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port start, input, 1, begin a run (sampled in IDLE only).
REQ-008 The block SHALL have port abort, input, 1, synchronous run cancel.
REQ-009 The block SHALL have port mode, input, 3, operand class: 0 RAND, 1 A_GE_B, 2 B_GE_A, 3 ZERO_A, 4 ZERO_B, 5 INF_A, 6 NAN_A, 7 NAN_B.
REQ-010 The block SHALL have port sel_mode, input, 2, operation: 0 mul, 1 div, 2/3 random.
REQ-011 The block SHALL have port count, input, CNT_W, number of transactions in the run.
REQ-012 The block SHALL have ports a and b, output, W, registered operands.
REQ-013 The block SHALL have port sel, output, 1, registered operation select (0 mul, 1 div).
REQ-014 The block SHALL have port valid, output, 1, operands valid; port ready, input, 1, downstream accept.
REQ-015 The block SHALL have ports busy, output, 1 (run in progress), done, output, 1 (one-cycle end-of-run pulse), gen_cnt, output, CNT_W (transfers accepted this run).

Function
REQ-016 The block SHALL implement FSM states IDLE, RUN, FIN; busy=1 exactly in RUN.
REQ-017 IDLE with start=1 and count>0: the block SHALL latch mode, sel_mode, count, load first operands, clear gen_cnt, and enter RUN with valid=1 on the next cycle.
REQ-018 IDLE with start=1 and count=0: the block SHALL go to FIN, assert no valid, and pulse done the following cycle.
REQ-019 A transfer SHALL occur on each cycle with valid=1 and ready=1; a, b, sel SHALL remain stable while valid=1 and ready=0.
REQ-020 On a transfer, gen_cnt SHALL increment; if gen_cnt+1 equals the latched count, valid SHALL drop next cycle and the FSM SHALL enter FIN, else the next operands SHALL load with valid held high (back-to-back, one transfer per cycle).
REQ-021 FIN SHALL assert done for exactly one cycle and return to IDLE; gen_cnt SHALL hold its final value until the next start.
REQ-022 start during RUN or FIN SHALL be ignored; latched configuration SHALL not change mid-run.
REQ-023 abort=1 in RUN SHALL return to IDLE next cycle with valid=0 and no done pulse; abort takes priority over a coincident transfer's count update (the transfer is still counted).
REQ-024 Two 32-bit Galois LFSRs (polynomial x^32+x^22+x^2+x+1), LA and LB, SHALL advance exactly once per operand load; operands are derived from their pre-advance state (raw = low W bits).
REQ-025 Normal operand SHALL be: sign 0, exponent = raw exponent field, replaced by all-ones-minus-one if all-ones, mantissa = raw mantissa field.
REQ-026 Mode RAND: a, b normal from LA, LB; A_GE_B/B_GE_A: normal a, b swapped when needed so that a>=b / b>=a (unsigned magnitude compare).
REQ-027 ZERO_A/ZERO_B SHALL force a/b to all-zero, other operand normal; INF_A SHALL force a = exponent all-ones, mantissa zero; NAN_A/NAN_B SHALL force a/b = exponent all-ones, mantissa MSB 1, rest 0.
REQ-028 sel SHALL equal sel_mode[0] for sel_mode<2, else LB bit 31 of the pre-advance state.

Reset
REQ-029 While arst=1 the block SHALL hold: state IDLE, a=0, b=0, sel=0, valid=0, busy=0, done=0, gen_cnt=0, LA=SEED_A, LB=SEED_B; reset mid-run SHALL abandon the run without done.

Verification
REQ-030 Defaults, mode 0, sel_mode 0, count 1, ready=1 -> a=32'h1234_5678, b=32'h7F7F_FFFF, sel=0, one transfer, done one cycle later, gen_cnt=1.
REQ-031 Mode 1, count 1 after reset -> a=32'h7F7F_FFFF, b=32'h1234_5678; mode 2 -> unswapped.
REQ-032 Mode 5 then mode 7, count 4, ready toggled 0/1 -> a=32'h7F80_0000 every transfer, b=32'h7FC0_0000 in mode 7, operands stable during ready=0, exactly 4 transfers.
REQ-033 count=0 start -> valid never asserted, done one pulse, gen_cnt=0.
REQ-034 count=10, abort after 3 transfers -> valid low next cycle, no done, gen_cnt=3; arst pulse mid-run of a second start -> all outputs reset values, next run reproduces REQ-030 operands.
REQ-035 EXP_W=5, MAN_W=10, count 1000, sel_mode 2 -> every a, b exponent never 5'h1F, sign 0, sel takes both values.

Source files
------------

// File: rtl/fp_muldiv_stim_gen.sv
// Operand stimulus generator for a floating-point mul/div unit: produces
// LFSR-derived or special-value operand pairs over a valid/ready stream.
module fp_muldiv_stim_gen #(
  parameter int          EXP_W  = 8,
  parameter int          MAN_W  = 23,
  parameter int          CNT_W  = 16,
  parameter logic [31:0] SEED_A = 32'h1234_5678,
  parameter logic [31:0] SEED_B = 32'h7FFF_FFFF,
  localparam int         W      = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       mode,
  input  logic [1:0]       sel_mode,
  input  logic [CNT_W-1:0] count,
  output logic [W-1:0]     a,
  output logic [W-1:0]     b,
  output logic             sel,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] gen_cnt,
  output logic [1:0]       state_dbg
);

  // Handshake: a transfer happens on every rising edge where valid=1 and
  // ready=1; while valid=1 and ready=0 the a/b/sel payload is held stable.

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_e;

  localparam logic [31:0]  LFSR_MASK = 32'h8020_0003;
  localparam logic [W-1:0] INF_V = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  localparam logic [W-1:0] NAN_V = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

  // Positive, finite operand: an all-ones exponent is pulled down by one.
  function automatic logic [W-1:0] norm_op(input logic [W-1:0] r);
    logic [EXP_W-1:0] e;
    e = r[W-2:MAN_W];
    if (&e) e = {{(EXP_W-1){1'b1}}, 1'b0};
    return {1'b0, e, r[MAN_W-1:0]};
  endfunction

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic             sel_q, sel_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic [CNT_W-1:0] gen_cnt_q, gen_cnt_d, cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic [1:0]       selm_q, selm_d;
  logic [31:0]      la_q, la_d, lb_q, lb_d;

  logic [2:0]       cur_mode;
  logic [1:0]       cur_selm;
  logic [W-1:0]     na, nb, gen_a, gen_b;
  logic             gen_sel, xfer;
  logic [CNT_W-1:0] cnt_inc;

  // Operand candidates use the live inputs in IDLE and the latched run config otherwise.
  always_comb begin
    cur_mode = (state_q == IDLE) ? mode : mode_q;
    cur_selm = (state_q == IDLE) ? sel_mode : selm_q;
    na       = norm_op(la_q[W-1:0]);
    nb       = norm_op(lb_q[W-1:0]);
    gen_a    = na;
    gen_b    = nb;
    case (cur_mode)
      3'd1:    if (na < nb) begin gen_a = nb; gen_b = na; end
      3'd2:    if (nb < na) begin gen_a = nb; gen_b = na; end
      3'd3:    gen_a = '0;
      3'd4:    gen_b = '0;
      3'd5:    gen_a = INF_V;
      3'd6:    gen_a = NAN_V;
      3'd7:    gen_b = NAN_V;
      default: ;
    endcase
    gen_sel = cur_selm[1] ? lb_q[31] : cur_selm[0];
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    gen_cnt_d = gen_cnt_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    selm_d    = selm_q;
    la_d      = la_q;
    lb_d      = lb_q;
    xfer      = valid_q & ready;
    cnt_inc   = gen_cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d    = mode;
          selm_d    = sel_mode;
          cnt_d     = count;
          gen_cnt_d = '0;
          if (count != '0) begin
            a_d     = gen_a;
            b_d     = gen_b;
            sel_d   = gen_sel;
            la_d    = lfsr_next(la_q);
            lb_d    = lfsr_next(lb_q);
            valid_d = 1'b1;
            state_d = RUN;
          end else begin
            done_d  = 1'b1;
            state_d = FIN;
          end
        end
      end
      RUN: begin
        if (xfer) gen_cnt_d = cnt_inc;
        if (abort) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (xfer) begin
          if (cnt_inc == cnt_q) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = FIN;
          end else begin
            a_d   = gen_a;
            b_d   = gen_b;
            sel_d = gen_sel;
            la_d  = lfsr_next(la_q);
            lb_d  = lfsr_next(lb_q);
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sel_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      gen_cnt_q <= '0;
      cnt_q     <= '0;
      mode_q    <= '0;
      selm_q    <= '0;
      la_q      <= SEED_A;
      lb_q      <= SEED_B;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      gen_cnt_q <= gen_cnt_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      selm_q    <= selm_d;
      la_q      <= la_d;
      lb_q      <= lb_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign sel       = sel_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign gen_cnt   = gen_cnt_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fp_muldiv_stim_gen.sv
// Directed bench for fp_muldiv_stim_gen: default 32-bit instance plus a
// 16-bit (EXP_W=5, MAN_W=10) instance for the long random-operation run.
module tb_fp_muldiv_stim_gen;

  localparam logic [31:0] SEED_A = 32'h1234_5678;
  localparam logic [31:0] SEED_B = 32'h7FFF_FFFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst = 1'b1;
  logic        start = 1'b0, abort = 1'b0, ready = 1'b1;
  logic [2:0]  mode = '0;
  logic [1:0]  sel_mode = '0;
  logic [15:0] count = '0;
  logic [31:0] a, b;
  logic        sel, valid, busy, done;
  logic [15:0] gen_cnt;
  logic [1:0]  state_dbg;

  logic        start2 = 1'b0, abort2 = 1'b0, ready2 = 1'b1;
  logic [2:0]  mode2 = '0;
  logic [1:0]  sel_mode2 = 2'd2;
  logic [15:0] count2 = '0;
  logic [15:0] a2, b2;
  logic        sel2, valid2, busy2, done2;
  logic [15:0] gen_cnt2;
  logic [1:0]  state_dbg2;

  fp_muldiv_stim_gen dut (
    .clk(clk), .arst(arst), .start(start), .abort(abort), .mode(mode),
    .sel_mode(sel_mode), .count(count), .a(a), .b(b), .sel(sel), .valid(valid),
    .ready(ready), .busy(busy), .done(done), .gen_cnt(gen_cnt), .state_dbg(state_dbg)
  );

  fp_muldiv_stim_gen #(.EXP_W(5), .MAN_W(10)) dut_small (
    .clk(clk), .arst(arst), .start(start2), .abort(abort2), .mode(mode2),
    .sel_mode(sel_mode2), .count(count2), .a(a2), .b(b2), .sel(sel2), .valid(valid2),
    .ready(ready2), .busy(busy2), .done(done2), .gen_cnt(gen_cnt2), .state_dbg(state_dbg2)
  );

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] la_m, lb_m;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic logic [31:0] norm32(input logic [31:0] s);
    logic [7:0] e;
    e = s[30:23];
    if (e == 8'hFF) e = 8'hFE;
    return {1'b0, e, s[22:0]};
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_b_q[$];
  logic        exp_sel_q[$];
  int          sb_idx = 0;

  task automatic push_exp(input logic [2:0] m, input logic [1:0] sm);
    logic [31:0] na, nb, ea, eb, t;
    na = norm32(la_m);
    nb = norm32(lb_m);
    ea = na;
    eb = nb;
    case (m)
      3'd1: if (ea < eb) begin t = ea; ea = eb; eb = t; end
      3'd2: if (eb < ea) begin t = ea; ea = eb; eb = t; end
      3'd3: ea = 32'h0;
      3'd4: eb = 32'h0;
      3'd5: ea = 32'h7F80_0000;
      3'd6: ea = 32'h7FC0_0000;
      3'd7: eb = 32'h7FC0_0000;
      default: ;
    endcase
    exp_q.push_back(ea);
    exp_b_q.push_back(eb);
    exp_sel_q.push_back(sm[1] ? lb_m[31] : sm[0]);
    la_m = lfsr_step(la_m);
    lb_m = lfsr_step(lb_m);
  endtask

  task automatic push_const(input logic [31:0] ea, input logic [31:0] eb, input logic es);
    exp_q.push_back(ea);
    exp_b_q.push_back(eb);
    exp_sel_q.push_back(es);
    la_m = lfsr_step(la_m);
    lb_m = lfsr_step(lb_m);
  endtask

  // ---------------- monitors ----------------
  int          xfers = 0, done_cnt = 0, valid_cycles = 0;
  logic        hold_prev = 1'b0;
  logic [31:0] prev_a, prev_b;
  logic        prev_sel;

  always @(negedge clk) begin
    if (valid && ready) begin
      xfers++;
      if (sb_idx < exp_q.size()) begin
        check_eq("xfer_a", a, exp_q[sb_idx]);
        check_eq("xfer_b", b, exp_b_q[sb_idx]);
        check_eq("xfer_sel", {31'h0, sel}, {31'h0, exp_sel_q[sb_idx]});
        sb_idx++;
      end
    end
    if (done) done_cnt++;
    if (valid) valid_cycles++;
    if (hold_prev && valid) begin
      check_eq("stall_a", a, prev_a);
      check_eq("stall_b", b, prev_b);
      check_eq("stall_sel", {31'h0, sel}, {31'h0, prev_sel});
    end
    hold_prev = valid && !ready;
    prev_a    = a;
    prev_b    = b;
    prev_sel  = sel;
  end

  int   xfers2 = 0;
  logic seen0 = 1'b0, seen1 = 1'b0;

  always @(negedge clk) begin
    if (valid2 && ready2) begin
      xfers2++;
      check_eq("small_a_exp", {31'h0, a2[14:10] != 5'h1F}, 32'h1);
      check_eq("small_b_exp", {31'h0, b2[14:10] != 5'h1F}, 32'h1);
      check_eq("small_sign", {30'h0, a2[15], b2[15]}, 32'h0);
      if (sel2) seen1 = 1'b1;
      else      seen0 = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  int xf0, dn0, vc0;

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_a"}, a, 32'h0);
    check_eq({tag, "_b"}, b, 32'h0);
    check_eq({tag, "_ctl"}, {28'h0, sel, valid, busy, done}, 32'h0);
    check_eq({tag, "_gen_cnt"}, {16'h0, gen_cnt}, 32'h0);
    check_eq({tag, "_state"}, {30'h0, state_dbg}, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk) #1;
    arst  = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk) #1;
    arst = 1'b0;
    la_m = SEED_A;
    lb_m = SEED_B;
  endtask

  // Config inputs are scrambled right after the start cycle so a run that
  // does not hold its latched configuration shows up in the scoreboard.
  task automatic start_run(input logic [2:0] m, input logic [1:0] sm, input logic [15:0] cnt);
    @(posedge clk) #1;
    mode     = m;
    sel_mode = sm;
    count    = cnt;
    start    = 1'b1;
    xf0      = xfers;
    dn0      = done_cnt;
    vc0      = valid_cycles;
    @(posedge clk) #1;
    start    = 1'b0;
    mode     = ~m;
    sel_mode = ~sm;
    count    = ~cnt;
  endtask

  task automatic wait_end(input int max_cyc, input logic toggle);
    int n;
    n = 0;
    while ((busy || done) && n < max_cyc) begin
      @(posedge clk) #1;
      if (toggle) ready = ~ready;
      n++;
    end
    check_eq("run_timeout", {31'h0, busy || done}, 32'h0);
    ready = 1'b1;
  endtask

  task automatic check_run(input string tag, input int nx, input int nd, input int ngc);
    check_eq({tag, "_xfers"}, xfers - xf0, nx);
    check_eq({tag, "_done"}, done_cnt - dn0, nd);
    check_eq({tag, "_gen_cnt"}, {16'h0, gen_cnt}, ngc);
    check_eq({tag, "_sb_drain"}, sb_idx, exp_q.size());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (2) @(posedge clk);
    do_reset();

    // Defaults, RAND, mul, single transfer.
    ready = 1'b1;
    push_const(32'h1234_5678, 32'h7F7F_FFFF, 1'b0);
    start_run(3'd0, 2'd0, 16'd1);
    wait_end(20, 1'b0);
    check_run("basic", 1, 1, 1);
    check_eq("basic_valid_cycles", valid_cycles - vc0, 1);

    // RAND, div, back-to-back transfers against the LFSR model.
    for (int i = 0; i < 3; i++) push_exp(3'd0, 2'd1);
    start_run(3'd0, 2'd1, 16'd3);
    wait_end(20, 1'b0);
    check_run("b2b", 3, 1, 3);
    check_eq("b2b_valid_cycles", valid_cycles - vc0, 3);

    // INF_A then NAN_B with ready toggling and random operation select.
    ready = 1'b0;
    for (int i = 0; i < 4; i++) push_exp(3'd5, 2'd3);
    start_run(3'd5, 2'd3, 16'd4);
    wait_end(40, 1'b1);
    check_run("inf_a", 4, 1, 4);
    ready = 1'b0;
    for (int i = 0; i < 4; i++) push_exp(3'd7, 2'd2);
    start_run(3'd7, 2'd2, 16'd4);
    wait_end(40, 1'b1);
    check_run("nan_b", 4, 1, 4);

    // Zero-length run.
    start_run(3'd0, 2'd0, 16'd0);
    wait_end(10, 1'b0);
    check_run("cnt0", 0, 1, 0);
    check_eq("cnt0_valid_cycles", valid_cycles - vc0, 0);

    // Abort coincident with the third transfer.
    start_run(3'd0, 2'd0, 16'd10);
    @(posedge clk) #1;
    @(posedge clk) #1;
    abort = 1'b1;
    @(posedge clk) #1;
    abort = 1'b0;
    @(negedge clk);
    check_eq("abort_ctl", {30'h0, valid, busy}, 32'h0);
    check_eq("abort_gen_cnt", {16'h0, gen_cnt}, 32'd3);
    repeat (4) @(negedge clk);
    check_eq("abort_done", done_cnt - dn0, 0);
    check_eq("abort_xfers", xfers - xf0, 3);
    check_eq("abort_hold_gen_cnt", {16'h0, gen_cnt}, 32'd3);

    // Reset in the middle of a run, then the first operands must repeat.
    start_run(3'd0, 2'd0, 16'd10);
    @(posedge clk) #1;
    @(posedge clk) #1;
    arst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk) #1;
    arst = 1'b0;
    la_m = SEED_A;
    lb_m = SEED_B;
    repeat (3) @(negedge clk);
    check_eq("midrst_done", done_cnt - dn0, 0);
    push_const(32'h1234_5678, 32'h7F7F_FFFF, 1'b0);
    start_run(3'd0, 2'd0, 16'd1);
    wait_end(20, 1'b0);
    check_run("post_rst", 1, 1, 1);

    // A_GE_B swaps the seed operands, B_GE_A leaves them in place.
    do_reset();
    push_const(32'h7F7F_FFFF, 32'h1234_5678, 1'b0);
    start_run(3'd1, 2'd0, 16'd1);
    wait_end(20, 1'b0);
    check_run("a_ge_b", 1, 1, 1);
    do_reset();
    push_const(32'h1234_5678, 32'h7F7F_FFFF, 1'b1);
    start_run(3'd2, 2'd1, 16'd1);
    wait_end(20, 1'b0);
    check_run("b_ge_a", 1, 1, 1);

    // Narrow-format instance, long run with random operation select.
    @(posedge clk) #1;
    count2 = 16'd1000;
    start2 = 1'b1;
    @(posedge clk) #1;
    start2 = 1'b0;
    n = 0;
    while ((busy2 || done2) && n < 1100) begin
      @(posedge clk) #1;
      n++;
    end
    check_eq("small_timeout", {31'h0, busy2 || done2}, 32'h0);
    check_eq("small_xfers", xfers2, 1000);
    check_eq("small_gen_cnt", {16'h0, gen_cnt2}, 32'd1000);
    check_eq("small_sel_both", {30'h0, seen1, seen0}, 32'h3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
